mcp_mem_arbiter: RTL and testbench



---
 rtl/mcp_mem_arbiter.sv | 64 ++++++
 tb/tb_mcp_mem_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mcp_mem_arbiter.sv
// mcp_mem_arbiter: 32x8 MCP data memory shared by CPU (A) and debug scanner (B)
// with round-robin req/gnt arbitration, 1-cycle read latency and contention count.
module mcp_mem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic [CNT_W-1:0]  conflict_cnt
);
    localparam int DEPTH = 1 << ADDR_W;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_last_b;
    logic              r_rvalid_a, r_rvalid_b;
    logic [DATA_W-1:0] r_rdata_a, r_rdata_b;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_gnt_a, w_gnt_b;
    // On a tie the port that did not transfer last wins.
    assign w_gnt_a = !reset && req_a && (!req_b || r_last_b);
    assign w_gnt_b = !reset && req_b && (!req_a || !r_last_b);
    assign gnt_a = w_gnt_a;
    assign gnt_b = w_gnt_b;
    assign rvalid_a = r_rvalid_a;
    assign rvalid_b = r_rvalid_b;
    assign rdata_a = r_rdata_a;
    assign rdata_b = r_rdata_b;
    assign conflict_cnt = r_cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= (i < 16) ? DATA_W'(i) : DATA_W'(16 - i);
            r_last_b <= 1'b1;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
            r_rdata_a <= '0;
            r_rdata_b <= '0;
            r_cnt <= '0;
        end else begin
            if (w_gnt_a && we_a) r_mem[addr_a] <= wdata_a;
            if (w_gnt_b && we_b) r_mem[addr_b] <= wdata_b;
            if (w_gnt_a && !we_a) r_rdata_a <= r_mem[addr_a];
            if (w_gnt_b && !we_b) r_rdata_b <= r_mem[addr_b];
            r_rvalid_a <= w_gnt_a && !we_a;
            r_rvalid_b <= w_gnt_b && !we_b;
            r_last_b <= w_gnt_b ? 1'b1 : w_gnt_a ? 1'b0 : r_last_b;
            if (req_a && req_b && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mcp_mem_arbiter.sv
// tb_mcp_mem_arbiter: directed checks of arbitration, latency, RAW, reset discard and saturation
module tb_mcp_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic req_a, we_a, req_b, we_b;
  logic [4:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
  logic gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [7:0] rdata_a, rdata_b, conflict_cnt;
  int checks = 0;
  int errors = 0;
  int n_ra, n_rb;
  mcp_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .conflict_cnt(conflict_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    {req_a, we_a, req_b, we_b} = '0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    tick(); tick();
    req_a = 1'b1; addr_a = 5'd2;
    #1;
    chk("rst_gnt_a", gnt_a, 1'b0);
    tick();
    chk("rst_rvalid_a", rvalid_a, 1'b0);
    chk("rst_rdata_a", rdata_a, 8'h00);
    chk("rst_rvalid_b", rvalid_b, 1'b0);
    chk("rst_cnt", conflict_cnt, 8'h00);
    reset = 1'b0; addr_a = 5'd17;
    #1;
    chk("t1_gnt_a", gnt_a, 1'b1);
    chk("t1_gnt_b", gnt_b, 1'b0);
    tick();
    req_a = 1'b0;
    chk("t1_rvalid_a", rvalid_a, 1'b1);
    chk("t1_rdata_a", rdata_a, 8'hFF);
    chk("t1_rvalid_b", rvalid_b, 1'b0);
    chk("t1_cnt", conflict_cnt, 8'h00);
    req_b = 1'b1; addr_b = 5'd0;
    #1;
    chk("b0_gnt_b", gnt_b, 1'b1);
    tick();
    req_b = 1'b0;
    chk("b0_rvalid_b", rvalid_b, 1'b1);
    chk("b0_rdata_b", rdata_b, 8'h00);
    chk("b0_rvalid_a", rvalid_a, 1'b0);
    req_a = 1'b1; addr_a = 5'd3; req_b = 1'b1; addr_b = 5'd31;
    #1;
    chk("t2_gnt_a", gnt_a, 1'b1);
    chk("t2_gnt_b0", gnt_b, 1'b0);
    tick();
    req_a = 1'b0;
    chk("t2_rvalid_a", rvalid_a, 1'b1);
    chk("t2_rdata_a", rdata_a, 8'h03);
    #1;
    chk("t2_gnt_b", gnt_b, 1'b1);
    tick();
    req_b = 1'b0;
    chk("t2_rvalid_b", rvalid_b, 1'b1);
    chk("t2_rdata_b", rdata_b, 8'hF1);
    chk("t2_rvalid_a0", rvalid_a, 1'b0);
    chk("t2_rdata_a_hold", rdata_a, 8'h03);
    chk("t2_cnt", conflict_cnt, 8'h01);
    req_a = 1'b1; addr_a = 5'd5; req_b = 1'b1; addr_b = 5'd6;
    n_ra = 0; n_rb = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t3_gnt_a", gnt_a, (k % 2 == 0));
      chk("t3_gnt_b", gnt_b, (k % 2 == 1));
      tick();
      n_ra += int'(rvalid_a);
      n_rb += int'(rvalid_b);
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("t3_pulses_a", n_ra, 3);
    chk("t3_pulses_b", n_rb, 3);
    chk("t3_rdata_a", rdata_a, 8'h05);
    chk("t3_rdata_b", rdata_b, 8'h06);
    chk("t3_cnt", conflict_cnt, 8'h07);
    req_a = 1'b1; we_a = 1'b1; addr_a = 5'd4; wdata_a = 8'h5A;
    #1;
    chk("t4_gnt_a", gnt_a, 1'b1);
    tick();
    req_a = 1'b0; we_a = 1'b0;
    req_b = 1'b1; addr_b = 5'd4;
    chk("t4_rvalid_a_wr", rvalid_a, 1'b0);
    #1;
    chk("t4_gnt_b", gnt_b, 1'b1);
    tick();
    req_b = 1'b0;
    chk("t4_rvalid_b", rvalid_b, 1'b1);
    chk("t4_rdata_b", rdata_b, 8'h5A);
    req_a = 1'b1; we_a = 1'b1; wdata_a = 8'h77;
    tick();
    req_a = 1'b0; we_a = 1'b0;
    reset = 1'b1; req_b = 1'b1; addr_b = 5'd9;
    #1;
    chk("t5_gnt_b_rst", gnt_b, 1'b0);
    tick();
    reset = 1'b0; req_b = 1'b0;
    chk("t5_rvalid_a_rst", rvalid_a, 1'b0);
    chk("t5_rvalid_b_rst", rvalid_b, 1'b0);
    chk("t5_cnt_rst", conflict_cnt, 8'h00);
    req_a = 1'b1; addr_a = 5'd4;
    tick();
    req_a = 1'b0;
    chk("t5_rvalid_a", rvalid_a, 1'b1);
    chk("t5_rdata_a", rdata_a, 8'h04);
    req_a = 1'b1; req_b = 1'b1; addr_a = 5'd1; addr_b = 5'd2;
    for (int i = 0; i < 300; i++) begin
      #1;
      chk("t6_gnt_a", gnt_a, (i % 2 == 1));
      chk("t6_gnt_b", gnt_b, (i % 2 == 0));
      tick();
      if (i == 253) chk("t6_cnt_254", conflict_cnt, 8'hFE);
      if (i == 254) chk("t6_cnt_255", conflict_cnt, 8'hFF);
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("t6_cnt_sat", conflict_cnt, 8'hFF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
